// File: rtl/sram_ctrl.sv
// Multi-cycle sequencer between the MEM stage and an external 32-bit async SRAM.
// Every SRAM-facing output is registered from the next state, so strobes never glitch.
module sram_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_n_i,
  input  logic              mem_we_n_i,
  input  logic              mem_oe_n_i,
  input  logic [3:0]        mem_be_n_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          wr_req, rd_req;
  logic          addr_unused;

  // Write wins when both strobes are low.
  assign wr_req = !mem_ce_n_i && !mem_we_n_i;
  assign rd_req = !mem_ce_n_i &&  mem_we_n_i && !mem_oe_n_i;

  assign stall_o     = !rst && (wr_req || rd_req) && (state != DONE);
  assign addr_unused = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (wr_req) state_nxt = WR_SETUP;
                else if (rd_req) state_nxt = RD;
      RD:       if (cnt == RD_LAST) state_nxt = DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt == WR_LAST) state_nxt = WR_HOLD;
      WR_HOLD:  state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
      sram_data_oe_o <= 1'b0;
      rdata_o        <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;

      // Strobe levels describe the state being entered.
      sram_ce_n_o    <= !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      sram_oe_n_o    <= (state_nxt != RD);
      sram_we_n_o    <= (state_nxt != WR_PULSE);
      sram_data_oe_o <= (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});

      // Request is captured only on leaving IDLE; later input changes are ignored.
      if (state == IDLE && state_nxt != IDLE) begin
        sram_addr_o <= mem_addr_i[ADDR_W+1:2];
        sram_be_n_o <= mem_be_n_i;
        sram_data_o <= mem_data_i;
      end else if (state_nxt == DONE) begin
        sram_be_n_o <= 4'hF;
      end

      if (state == RD && state_nxt == DONE)
        rdata_o <= sram_data_i;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (RD_CYCLES=2, WR_CYCLES=2): latency, strobe shape,
// back-to-back accesses, mid-access reset and request decode priority.
module tb_sram_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_n, mem_we_n, mem_oe_n;
  logic [3:0]  mem_be_n;
  logic [31:0] mem_addr, mem_data;
  logic [31:0] rdata;
  logic        stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ADDR_W(20), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_n_i(mem_ce_n), .mem_we_n_i(mem_we_n), .mem_oe_n_i(mem_oe_n),
    .mem_be_n_i(mem_be_n), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .rdata_o(rdata), .stall_o(stall),
    .sram_addr_o(sram_addr), .sram_data_o(sram_wdata), .sram_data_oe_o(sram_data_oe),
    .sram_data_i(sram_rdata),
    .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n),
    .sram_be_n_o(sram_be_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic ce, input logic we, input logic oe, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] d);
    mem_ce_n = ce; mem_we_n = we; mem_oe_n = oe; mem_be_n = be; mem_addr = a; mem_data = d;
  endtask

  // Called at a negedge with the request applied; returns in the first cycle with stall low.
  task automatic run(output int st, output int wl, output int ol, output int su,
                     output int ho, output int ov,
                     output logic [31:0] a, output logic [31:0] b, output logic [31:0] d);
    bit seen_we = 1'b0;
    st = 0; wl = 0; ol = 0; su = 0; ho = 0; ov = 0; a = '0; b = '0; d = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) break;
      st++;
      if (!sram_we_n) begin wl++; seen_we = 1'b1; a = 32'(sram_addr); b = 32'(sram_be_n); d = sram_wdata; end
      if (!sram_oe_n) begin ol++; a = 32'(sram_addr); b = 32'(sram_be_n); end
      if (sram_data_oe && sram_we_n) begin
        if (seen_we) ho++; else su++;
      end
      if (!sram_we_n && !sram_oe_n) ov++;
      @(negedge clk);
    end
  endtask

  int st, wl, ol, su, ho, ov;
  logic [31:0] a, b, d;
  int waited;

  initial begin
    rst = 1'b1;
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    sram_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: plain read
    sram_rdata = 32'hDEADBEEF;
    req(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("rd_stall_cycles", 32'(st), 32'd3);
    chk("rd_oe_cycles", 32'(ol), 32'd2);
    chk("rd_addr", a, 32'h4);
    chk("rd_we_cycles", 32'(wl), 32'd0);
    chk("rd_rdata_done", rdata, 32'hDEADBEEF);
    chk("rd_done_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rd_done_ce_n", 32'(sram_ce_n), 32'd1);
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    sram_rdata = 32'h0;
    @(negedge clk);

    // 2: byte write
    req(1'b0, 1'b0, 1'b1, 4'b0111, 32'h0000_0013, 32'h5A5A5A5A);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("wr_stall_cycles", 32'(st), 32'd5);
    chk("wr_we_cycles", 32'(wl), 32'd2);
    chk("wr_setup", 32'(su), 32'd1);
    chk("wr_hold", 32'(ho), 32'd1);
    chk("wr_addr", a, 32'h4);
    chk("wr_be_n", b, 32'h7);
    chk("wr_data", d, 32'h5A5A5A5A);
    chk("wr_done_data_oe", 32'(sram_data_oe), 32'd0);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);

    // 3: LW then SW back to back
    sram_rdata = 32'h12345678;
    req(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("b2b_lw_stall", 32'(st), 32'd3);
    chk("b2b_lw_addr", a, 32'h8);
    chk("b2b_lw_rdata", rdata, 32'h12345678);
    sram_rdata = 32'hFFFF0000;
    req(1'b0, 1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'hA5A5_0F0F);
    @(negedge clk);
    #1;
    chk("b2b_idle_ce_n", 32'(sram_ce_n), 32'd1);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("b2b_sw_stall", 32'(st), 32'd5);
    chk("b2b_sw_addr", a, 32'h10);
    chk("b2b_sw_data", d, 32'hA5A5_0F0F);
    chk("b2b_sw_overlap", 32'(ov + ol), 32'd0);
    chk("b2b_sw_rdata_kept", rdata, 32'h12345678);
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);

    // 4: reset in the middle of the write pulse
    req(1'b0, 1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0BAD_F00D);
    waited = 0;
    #1;
    while (sram_we_n && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("rstmid_reached_pulse", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstmid_stall_comb", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid_data_oe", 32'(sram_data_oe), 32'd0);
    chk("rstmid_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rstmid_rdata", rdata, 32'h0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    sram_rdata = 32'hCAFEF00D;
    req(1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("rstmid_next_rd_stall", 32'(st), 32'd3);
    chk("rstmid_next_rd_rdata", rdata, 32'hCAFEF00D);
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);

    // 5: both strobes low decodes as write; both high is no access
    req(1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0004, 32'h1111_2222);
    run(st, wl, ol, su, ho, ov, a, b, d);
    chk("both_low_stall", 32'(st), 32'd5);
    chk("both_low_we", 32'(wl), 32'd2);
    chk("both_low_oe", 32'(ol), 32'd0);
    chk("both_low_rdata_kept", rdata, 32'hCAFEF00D);
    req(1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    req(1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("noacc_stall", 32'(stall), 32'd0);
      chk("noacc_ce_n", 32'(sram_ce_n), 32'd1);
      @(negedge clk);
    end
    req(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("ce_high_stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
